// File: rtl/cache_ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_ctrl_fsm_if
// Description : CPU, cache-array and memory buses of the cache controller.
//               The master modport is the controller side.
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_ctrl_fsm_if #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = 256,
    parameter int TAG_WIDTH  = 15
) ();
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_ready;

    logic [ADDR_WIDTH-1:0] cm_addr;
    logic [BLOCK_SIZE-1:0] cm_data_write;
    logic                  cm_dirty_write;
    logic                  cm_write_en;
    logic [BLOCK_SIZE-1:0] cm_data_read;
    logic                  cm_dirty_read;
    logic                  cm_hit;
    logic [TAG_WIDTH-1:0]  cm_replace_tag;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [BLOCK_SIZE-1:0] mem_wdata;
    logic [BLOCK_SIZE-1:0] mem_rdata;
    logic                  mem_ack;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cm_data_read, cm_dirty_read, cm_hit, cm_replace_tag,
        input  mem_rdata, mem_ack,
        output cpu_rdata, cpu_ready,
        output cm_addr, cm_data_write, cm_dirty_write, cm_write_en,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cm_data_read, cm_dirty_read, cm_hit, cm_replace_tag,
        output mem_rdata, mem_ack,
        input  cpu_rdata, cpu_ready,
        input  cm_addr, cm_data_write, cm_dirty_write, cm_write_en,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/cache_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : cache_ctrl_fsm
// Description : Direct-mapped cache sequencer: lookup, dirty writeback, line
//               fill, array update, CPU response. Optional hit/miss/writeback
//               counters when CACHE_CTRL_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_ctrl_fsm #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = 256,
    parameter int TAG_WIDTH  = 15
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    cache_ctrl_fsm_if.master     bus
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [31:0]          stat_hits,
    output logic [31:0]          stat_misses,
    output logic [31:0]          stat_wbacks
`endif
);
    localparam int c_WORDS    = BLOCK_SIZE / DATA_WIDTH;
    localparam int c_OFFSET_W = $clog2(c_WORDS);
    localparam int c_INDEX_W  = ADDR_WIDTH - TAG_WIDTH - c_OFFSET_W;
    localparam int c_BASE_W   = $clog2(BLOCK_SIZE);
    localparam int c_DW_LOG   = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOOKUP    = 3'd1,
        S_COMPARE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_FILL      = 3'd4,
        S_UPDATE    = 3'd5,
        S_RESPOND   = 3'd6
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [BLOCK_SIZE-1:0] r_line;    // victim/hit line, then fill data
    logic [TAG_WIDTH-1:0]  r_vtag;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic [c_OFFSET_W-1:0] w_offset;
    logic [c_INDEX_W-1:0]  w_index;
    logic [TAG_WIDTH-1:0]  w_tag;
    logic [c_BASE_W-1:0]   w_bit_base;
    logic [BLOCK_SIZE-1:0] w_merged;

    assign w_offset   = r_addr[c_OFFSET_W-1:0];
    assign w_index    = r_addr[c_OFFSET_W +: c_INDEX_W];
    assign w_tag      = r_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign w_bit_base = {w_offset, {c_DW_LOG{1'b0}}};

    always_comb begin
        w_merged = r_line;
        w_merged[w_bit_base +: DATA_WIDTH] = r_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_line  <= '0;
            r_vtag  <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (bus.cpu_req) begin
                        r_addr  <= bus.cpu_addr;
                        r_we    <= bus.cpu_we;
                        r_wdata <= bus.cpu_wdata;
                    end
                end
                S_COMPARE: begin
                    r_line  <= bus.cm_data_read;
                    r_vtag  <= bus.cm_replace_tag;
                    r_rdata <= (bus.cm_hit && !r_we) ?
                               bus.cm_data_read[w_bit_base +: DATA_WIDTH] : '0;
                end
                S_FILL: begin
                    if (bus.mem_ack) begin
                        r_line  <= bus.mem_rdata;
                        r_rdata <= r_we ? '0 : bus.mem_rdata[w_bit_base +: DATA_WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next       = r_state;
        bus.cpu_rdata      = '0;
        bus.cpu_ready      = 1'b0;
        bus.cm_addr        = r_addr;
        bus.cm_data_write  = '0;
        bus.cm_dirty_write = 1'b0;
        bus.cm_write_en    = 1'b0;
        bus.mem_req        = 1'b0;
        bus.mem_we         = 1'b0;
        bus.mem_addr       = '0;
        bus.mem_wdata      = '0;
        case (r_state)
            S_IDLE:   if (bus.cpu_req) w_state_next = S_LOOKUP;
            S_LOOKUP: w_state_next = S_COMPARE;
            S_COMPARE: begin
                if (bus.cm_hit)             w_state_next = r_we ? S_UPDATE : S_RESPOND;
                else if (bus.cm_dirty_read) w_state_next = S_WRITEBACK;
                else                        w_state_next = S_FILL;
            end
            S_WRITEBACK: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = {r_vtag, w_index, {c_OFFSET_W{1'b0}}};
                bus.mem_wdata = r_line;
                if (bus.mem_ack) w_state_next = S_FILL;
            end
            S_FILL: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = {w_tag, w_index, {c_OFFSET_W{1'b0}}};
                if (bus.mem_ack) w_state_next = S_UPDATE;
            end
            S_UPDATE: begin
                bus.cm_write_en    = 1'b1;
                bus.cm_data_write  = r_we ? w_merged : r_line;
                bus.cm_dirty_write = r_we;
                w_state_next       = S_RESPOND;
            end
            S_RESPOND: begin
                bus.cpu_ready = 1'b1;
                bus.cpu_rdata = r_rdata;
                w_state_next  = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

`ifdef CACHE_CTRL_STATS_EN
    logic [31:0] r_stat_hits;
    logic [31:0] r_stat_misses;
    logic [31:0] r_stat_wbacks;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_hits   <= '0;
            r_stat_misses <= '0;
            r_stat_wbacks <= '0;
        end else begin
            if (r_state == S_COMPARE) begin
                if (bus.cm_hit) begin
                    if (r_stat_hits != '1) r_stat_hits <= r_stat_hits + 32'd1;
                end else begin
                    if (r_stat_misses != '1) r_stat_misses <= r_stat_misses + 32'd1;
                end
            end
            if (r_state == S_WRITEBACK && bus.mem_ack && r_stat_wbacks != '1)
                r_stat_wbacks <= r_stat_wbacks + 32'd1;
        end
    end

    assign stat_hits   = r_stat_hits;
    assign stat_misses = r_stat_misses;
    assign stat_wbacks = r_stat_wbacks;
`endif
endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_ctrl_fsm
// Description : Bench for cache_ctrl_fsm with cache-array and memory models
//               and a transaction-level reference cache.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_ctrl_fsm;
    localparam int AW = 28;
    localparam int DW = 32;
    localparam int BS = 256;
    localparam int TW = 15;

    typedef struct { logic we; logic [AW-1:0] addr; logic [BS-1:0] data; } mem_op_t;
    typedef struct { logic [AW-1:0] addr; logic [BS-1:0] data; logic dirty; } cm_wr_t;

    logic clk;
    logic rst_n;

    cache_ctrl_fsm_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_SIZE(BS), .TAG_WIDTH(TW)) bus ();

`ifdef CACHE_CTRL_STATS_EN
    logic [31:0] stat_hits, stat_misses, stat_wbacks;
`endif

    cache_ctrl_fsm #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_SIZE(BS), .TAG_WIDTH(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef CACHE_CTRL_STATS_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses),
        .stat_wbacks (stat_wbacks)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int req_cyc = 0;
    int mem_lat = 1;
    bit busy    = 0;
    bit done    = 0;
    bit inj_ack = 0;
    logic [AW-1:0] cur_addr;

    // reference cache: expectations for the transaction in flight
    mem_op_t exp_mem[$];
    cm_wr_t  exp_cmw[$];
    logic [31:0]   e_rdata;
    int            e_lat;
    logic [9:0]    p_idx;
    logic [TW-1:0] p_tag;
    logic [BS-1:0] p_line;
    logic          p_dirty;
    bit            p_wb;
    logic [AW-1:0] p_wb_addr;
    logic [BS-1:0] p_wb_data;
    bit            m_valid [1024];
    logic [TW-1:0] m_tag   [1024];
    bit            m_dirty [1024];
    logic [BS-1:0] m_data  [1024];
    logic [BS-1:0] ref_mem [logic [AW-1:0]];

    // environment: cache array and memory seen by the DUT
    bit            a_valid [1024];
    logic [TW-1:0] a_tag   [1024];
    bit            a_dirty [1024];
    logic [BS-1:0] a_data  [1024];
    logic [BS-1:0] env_mem [logic [AW-1:0]];

    logic          obs_we   [$];
    logic [AW-1:0] obs_addr [$];
    int            n_cmw;
    logic [BS-1:0] last_cmw_data;
    logic          last_cmw_dirty;
    logic [31:0]   last_rdata;
    int            last_lat;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [BS-1:0] act, input logic [BS-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event occurred, none expected", name);
    endtask

    function automatic logic [BS-1:0] init_line(input logic [AW-1:0] la);
        logic [BS-1:0] l;
        for (int i = 0; i < 8; i++) begin
            logic [3:0] w;
            w = i[3:0];
            l[i*32 +: 32] = {la[19:0], w, 8'hAA};
        end
        return l;
    endfunction

    function automatic logic [BS-1:0] model_line(input logic [AW-1:0] la);
        return ref_mem.exists(la) ? ref_mem[la] : init_line(la);
    endfunction

    function automatic logic [BS-1:0] env_line(input logic [AW-1:0] la);
        return env_mem.exists(la) ? env_mem[la] : init_line(la);
    endfunction

    task automatic predict(input logic we, input logic [AW-1:0] addr, input logic [31:0] wdata);
        logic [9:0]    idx;
        logic [TW-1:0] tag;
        int            off;
        logic [BS-1:0] line;
        logic [AW-1:0] la;
        mem_op_t       mo;
        cm_wr_t        cw;
        idx  = addr[12:3];
        tag  = addr[27:13];
        off  = int'(addr[2:0]);
        p_wb = 0;
        if (m_valid[idx] && m_tag[idx] == tag) begin
            line = m_data[idx];
            if (we) begin
                line[off*32 +: 32] = wdata;
                cw.addr = addr; cw.data = line; cw.dirty = 1'b1;
                exp_cmw.push_back(cw);
                e_lat = 4; e_rdata = 32'h0; p_dirty = 1'b1;
            end else begin
                e_lat = 3; e_rdata = line[off*32 +: 32]; p_dirty = m_dirty[idx];
            end
        end else begin
            e_lat = 4 + mem_lat;
            if (m_valid[idx] && m_dirty[idx]) begin
                mo.we = 1'b1; mo.addr = {m_tag[idx], idx, 3'b000}; mo.data = m_data[idx];
                exp_mem.push_back(mo);
                e_lat += mem_lat;
                p_wb = 1; p_wb_addr = mo.addr; p_wb_data = mo.data;
            end
            la = {tag, idx, 3'b000};
            mo.we = 1'b0; mo.addr = la; mo.data = '0;
            exp_mem.push_back(mo);
            line = model_line(la);
            if (we) begin
                line[off*32 +: 32] = wdata;
                e_rdata = 32'h0; p_dirty = 1'b1;
            end else begin
                e_rdata = line[off*32 +: 32]; p_dirty = 1'b0;
            end
            cw.addr = addr; cw.data = line; cw.dirty = we;
            exp_cmw.push_back(cw);
        end
        p_idx = idx; p_tag = tag; p_line = line;
    endtask

    task automatic commit();
        m_valid[p_idx] = 1; m_tag[p_idx] = p_tag; m_data[p_idx] = p_line; m_dirty[p_idx] = p_dirty;
        if (p_wb) ref_mem[p_wb_addr] = p_wb_data;
    endtask

    // array: registered read of the previous cycle's cm_addr; memory: ack after mem_lat cycles
    initial begin : env
        logic [AW-1:0] s_addr;
        logic          s_we, s_dirty;
        logic [BS-1:0] s_data;
        logic [9:0]    idx;
        int            cnt;
        cnt = 0;
        for (int i = 0; i < 1024; i++) begin
            a_valid[i] = 0; a_tag[i] = '0; a_dirty[i] = 0; a_data[i] = '0;
        end
        bus.cm_data_read = '0; bus.cm_dirty_read = 1'b0; bus.cm_hit = 1'b0;
        bus.cm_replace_tag = '0; bus.mem_rdata = '0; bus.mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            s_addr = bus.cm_addr; s_we = bus.cm_write_en;
            s_data = bus.cm_data_write; s_dirty = bus.cm_dirty_write;
            @(posedge clk);
            #2;
            idx = s_addr[12:3];
            if (s_we) begin
                a_data[idx] = s_data; a_tag[idx] = s_addr[27:13];
                a_valid[idx] = 1; a_dirty[idx] = s_dirty;
            end
            bus.cm_data_read   = a_data[idx];
            bus.cm_dirty_read  = a_valid[idx] && a_dirty[idx];
            bus.cm_hit         = a_valid[idx] && (a_tag[idx] == s_addr[27:13]);
            bus.cm_replace_tag = a_tag[idx];
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = '0;
            if (inj_ack) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = {8{32'hBADBAD00}};
                cnt = 0;
            end else if (bus.mem_req) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    cnt = 0;
                    bus.mem_ack = 1'b1;
                    if (bus.mem_we) env_mem[bus.mem_addr] = bus.mem_wdata;
                    else            bus.mem_rdata = env_line(bus.mem_addr);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (bus.mem_req) begin
                    if (exp_mem.size() == 0) fail_evt("mem_req_unexpected");
                    else begin
                        chk("mem_we", bus.mem_we, exp_mem[0].we);
                        chk("mem_addr", bus.mem_addr, exp_mem[0].addr);
                        if (exp_mem[0].we) chk("mem_wdata", bus.mem_wdata, exp_mem[0].data);
                        if (bus.mem_ack) begin
                            obs_we.push_back(bus.mem_we);
                            obs_addr.push_back(bus.mem_addr);
                            void'(exp_mem.pop_front());
                        end
                    end
                end
                if (bus.cm_write_en) begin
                    n_cmw++;
                    last_cmw_data  = bus.cm_data_write;
                    last_cmw_dirty = bus.cm_dirty_write;
                    if (exp_cmw.size() == 0) fail_evt("cm_write_unexpected");
                    else begin
                        chk("cm_wr_addr", bus.cm_addr, exp_cmw[0].addr);
                        chk("cm_wr_data", bus.cm_data_write, exp_cmw[0].data);
                        chk("cm_wr_dirty", bus.cm_dirty_write, exp_cmw[0].dirty);
                        void'(exp_cmw.pop_front());
                    end
                end
                if (busy && cyc > req_cyc) chk("cm_addr", bus.cm_addr, cur_addr);
                if (bus.cpu_ready) begin
                    if (!busy) fail_evt("cpu_ready_unexpected");
                    else begin
                        last_rdata = bus.cpu_rdata;
                        last_lat   = cyc - req_cyc;
                        chk("cpu_rdata", bus.cpu_rdata, e_rdata);
                        chk("latency", last_lat, e_lat);
                        chk("mem_ops_left", exp_mem.size(), 0);
                        chk("cm_writes_left", exp_cmw.size(), 0);
                        commit();
                        busy = 0;
                        done = 1;
                    end
                end
            end
        end
    end

    task automatic start_req(input logic we, input logic [AW-1:0] addr, input logic [31:0] wdata, input int lat);
        mem_lat = lat;
        exp_mem.delete(); exp_cmw.delete();
        obs_we.delete(); obs_addr.delete();
        n_cmw = 0; done = 0;
        predict(we, addr, wdata);
        @(posedge clk);
        #1;
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        cur_addr = addr; req_cyc = cyc + 1; busy = 1;
    endtask

    task automatic do_op(input logic we, input logic [AW-1:0] addr, input logic [31:0] wdata, input int lat);
        start_req(we, addr, wdata, lat);
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            if (done) break;
        end
        if (!done) begin
            fail_evt("cpu_ready_timeout");
            busy = 0;
        end
        #1;
        bus.cpu_req = 1'b0;
    endtask

    task automatic pin_mem(input string name, input int k, input logic we, input logic [AW-1:0] a);
        if (obs_addr.size() > k) begin
            chk({name, "_we"}, obs_we[k], we);
            chk({name, "_addr"}, obs_addr[k], a);
        end else fail_evt({name, "_missing"});
    endtask

    task automatic chk_idle_outputs(input string pfx);
        chk({pfx, "_cpu_ready"}, bus.cpu_ready, 0);
        chk({pfx, "_cpu_rdata"}, bus.cpu_rdata, 0);
        chk({pfx, "_cm_addr"}, bus.cm_addr, 0);
        chk({pfx, "_cm_wen"}, {bus.cm_write_en, bus.cm_dirty_write}, 0);
        chk({pfx, "_cm_data"}, bus.cm_data_write, 0);
        chk({pfx, "_mem_req"}, {bus.mem_req, bus.mem_we}, 0);
        chk({pfx, "_mem_addr"}, bus.mem_addr, 0);
        chk({pfx, "_mem_wdata"}, bus.mem_wdata, 0);
    endtask

    initial begin : main
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        do_op(1'b0, 28'h0000010, 32'h0, 2);
        chk("cold_rdata", last_rdata, 32'h000100AA);
        chk("cold_lat", last_lat, 6);
        chk("cold_nmem", obs_addr.size(), 1);
        pin_mem("cold_fill", 0, 1'b0, 28'h0000010);
        chk("cold_dirty", last_cmw_dirty, 0);

        do_op(1'b0, 28'h0000013, 32'h0, 2);
        chk("hit_rdata", last_rdata, 32'h000103AA);
        chk("hit_lat", last_lat, 3);
        chk("hit_nmem", obs_addr.size(), 0);

        do_op(1'b1, 28'h0000012, 32'hDEADBEEF, 2);
        chk("wrhit_lat", last_lat, 4);
        chk("wrhit_ncmw", n_cmw, 1);
        chk("wrhit_dirty", last_cmw_dirty, 1);
        chk("wrhit_word", last_cmw_data[95:64], 32'hDEADBEEF);
        chk("wrhit_rdata", last_rdata, 32'h0);

        do_op(1'b0, 28'h0000012, 32'h0, 2);
        chk("rdback", last_rdata, 32'hDEADBEEF);

        do_op(1'b0, 28'h0002010, 32'h0, 3);
        pin_mem("evict_wb", 0, 1'b1, 28'h0000010);
        pin_mem("evict_fill", 1, 1'b0, 28'h0002010);
        chk("evict_rdata", last_rdata, 32'h020100AA);
        chk("evict_lat", last_lat, 10);

        do_op(1'b1, 28'h0004018, 32'h12345678, 1);
        chk("wrmiss_nmem", obs_addr.size(), 1);
        chk("wrmiss_w0", last_cmw_data[31:0], 32'h12345678);
        chk("wrmiss_w1", last_cmw_data[63:32], 32'h040181AA);
        chk("wrmiss_dirty", last_cmw_dirty, 1);
        chk("wrmiss_lat", last_lat, 5);

        do_op(1'b1, 28'h0006019, 32'hCAFEF00D, 2);
        pin_mem("wrdirty_wb", 0, 1'b1, 28'h0004018);
        chk("wrdirty_lat", last_lat, 8);

        do_op(1'b0, 28'h0004018, 32'h0, 1);
        chk("wbdata_rdata", last_rdata, 32'h12345678);
        do_op(1'b0, 28'h0006019, 32'h0, 1);
        chk("wbdata2_rdata", last_rdata, 32'hCAFEF00D);

        // abort during a long fill, then a stray ack while idle
        start_req(1'b0, 28'h0000100, 32'h0, 20);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.cpu_req = 1'b0;
        @(posedge clk);
        #1;
        exp_mem.delete(); exp_cmw.delete();
        busy = 0;
        rst_n = 1'b1;
        inj_ack = 1'b1;
        @(negedge clk);
        chk_idle_outputs("abort");
        @(posedge clk);
        #1 inj_ack = 1'b0;
        repeat (3) @(posedge clk);

        do_op(1'b0, 28'h0000100, 32'h0, 1);
        chk("postrst_rdata", last_rdata, 32'h001000AA);
        chk("postrst_lat", last_lat, 5);
        pin_mem("postrst_fill", 0, 1'b0, 28'h0000100);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
